// File: rtl/bounding_box_top.sv
// bounding_box_top
// Scans an IMG_W x IMG_H single-channel image held in on-chip RAM in raster
// order and reports the axis-aligned bounding box of all foreground pixels.
// A scan starts on every release of KEY[3] (async active-low reset). When
// the last pixel has been judged, done rises and the box is frozen until the
// next reset.
//
// Optional feature macro: BBOX_THRESHOLD_EN
//   defined   : foreground is pixel >= THRESHOLD
//   undefined : foreground is any nonzero pixel (THRESHOLD ignored)
//
// An empty image leaves xMin/yMin at all ones and xMax/yMax at zero, so
// xMin > xMax marks "no object".

module bounding_box_top #(
  parameter int IMG_W     = 100,
  parameter int IMG_H     = 100,
  parameter int PIX_W     = 8,
  parameter int COORD_W   = 7,
  parameter int THRESHOLD = 128
) (
  input  logic       CLOCK_50,
  input  logic [3:0] KEY
);

  localparam int NPIX   = IMG_W * IMG_H;
  localparam int ADDR_W = $clog2(NPIX);

  localparam logic [ADDR_W-1:0]  LAST_ADDR  = ADDR_W'(NPIX - 1);
  localparam logic [ADDR_W-1:0]  ADDR_ZERO  = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0]  ADDR_ONE   = ADDR_W'(1);
  localparam logic [COORD_W-1:0] X_LAST     = COORD_W'(IMG_W - 1);
  localparam logic [COORD_W-1:0] COORD_ZERO = {COORD_W{1'b0}};
  localparam logic [COORD_W-1:0] COORD_ONE  = COORD_W'(1);
  localparam logic [COORD_W-1:0] COORD_ONES = {COORD_W{1'b1}};
  localparam logic [PIX_W-1:0]   PIX_ZERO   = {PIX_W{1'b0}};
  localparam logic [PIX_W-1:0]   THRESH_C   = PIX_W'(THRESHOLD);

  typedef enum logic [0:0] {
    SCAN = 1'b0,
    DONE = 1'b1
  } state_t;

  // Board-level aliases
  logic clk_s;
  logic rst_n_s;

  assign clk_s   = CLOCK_50;
  assign rst_n_s = KEY[3];

  // Image memory: word address y*IMG_W+x, filled externally, never cleared
  logic [PIX_W-1:0] ram [0:NPIX-1];

  // Control state
  state_t state_r;
  state_t state_s;

  // Read-side raster counters (address advances with x/y, no division)
  logic                rd_active_r;
  logic [COORD_W-1:0]  x_r;
  logic [COORD_W-1:0]  y_r;
  logic [ADDR_W-1:0]   addr_r;

  // Read-data stage with its coordinate tag carried alongside
  logic [PIX_W-1:0]    pix_r;
  logic                vld_r;
  logic [COORD_W-1:0]  tag_x_r;
  logic [COORD_W-1:0]  tag_y_r;
  logic                tag_last_r;

  // Results (names kept as the board-level observers expect them)
  logic                done;
  logic [COORD_W-1:0]  xMin;
  logic [COORD_W-1:0]  yMin;
  logic [COORD_W-1:0]  xMax;
  logic [COORD_W-1:0]  yMax;

  // Next-value terms
  logic                fg_s;
  logic                done_s;
  logic [COORD_W-1:0]  x_min_s;
  logic [COORD_W-1:0]  y_min_s;
  logic [COORD_W-1:0]  x_max_s;
  logic [COORD_W-1:0]  y_max_s;

  // KEY[2:0] are not used by this block
  logic unused_s;

`ifdef BBOX_THRESHOLD_EN
  assign fg_s     = (pix_r >= THRESH_C);
  assign unused_s = ^KEY[2:0];
`else
  assign fg_s     = (pix_r != PIX_ZERO);
  assign unused_s = ^{KEY[2:0], THRESH_C};
`endif

  // Issue one synchronous RAM read per clock and advance the raster counters
  always_ff @(posedge clk_s or negedge rst_n_s) begin
    if (!rst_n_s) begin
      rd_active_r <= 1'b1;
      x_r         <= COORD_ZERO;
      y_r         <= COORD_ZERO;
      addr_r      <= ADDR_ZERO;
      pix_r       <= PIX_ZERO;
      vld_r       <= 1'b0;
      tag_x_r     <= COORD_ZERO;
      tag_y_r     <= COORD_ZERO;
      tag_last_r  <= 1'b0;
    end else if ((state_r == SCAN) && rd_active_r) begin
      pix_r      <= ram[addr_r];
      vld_r      <= 1'b1;
      tag_x_r    <= x_r;
      tag_y_r    <= y_r;
      tag_last_r <= (addr_r == LAST_ADDR);
      if (addr_r == LAST_ADDR) begin
        // Counters park on the last pixel; no wrap-around
        rd_active_r <= 1'b0;
      end else begin
        addr_r <= addr_r + ADDR_ONE;
        if (x_r == X_LAST) begin
          x_r <= COORD_ZERO;
          y_r <= y_r + COORD_ONE;
        end else begin
          x_r <= x_r + COORD_ONE;
        end
      end
    end else begin
      vld_r      <= 1'b0;
      tag_last_r <= 1'b0;
    end
  end

  // Next state, bounding-box update and done flag from the judged pixel
  always_comb begin
    state_s = state_r;
    x_min_s = xMin;
    y_min_s = yMin;
    x_max_s = xMax;
    y_max_s = yMax;
    done_s  = 1'b0;
    case (state_r)
      SCAN: begin
        if (vld_r) begin
          if (fg_s) begin
            x_min_s = (tag_x_r < xMin) ? tag_x_r : xMin;
            x_max_s = (tag_x_r > xMax) ? tag_x_r : xMax;
            y_min_s = (tag_y_r < yMin) ? tag_y_r : yMin;
            y_max_s = (tag_y_r > yMax) ? tag_y_r : yMax;
          end else begin
            x_min_s = xMin;
          end
          if (tag_last_r) begin
            state_s = DONE;
          end else begin
            state_s = SCAN;
          end
        end else begin
          state_s = SCAN;
        end
      end
      DONE: begin
        state_s = DONE;
        done_s  = 1'b1;
      end
      default: begin
        state_s = SCAN;
        done_s  = 1'b0;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk_s or negedge rst_n_s) begin
    if (!rst_n_s) begin
      state_r <= SCAN;
    end else begin
      state_r <= state_s;
    end
  end

  // Registered results: bounding box and done
  always_ff @(posedge clk_s or negedge rst_n_s) begin
    if (!rst_n_s) begin
      done <= 1'b0;
      xMin <= COORD_ONES;
      yMin <= COORD_ONES;
      xMax <= COORD_ZERO;
      yMax <= COORD_ZERO;
    end else begin
      done <= done_s;
      xMin <= x_min_s;
      yMin <= y_min_s;
      xMax <= x_max_s;
      yMax <= y_max_s;
    end
  end

endmodule

// File: tb/tb_bounding_box_top.sv
// Self-checking bench for bounding_box_top: loads images into the DUT RAM
// while reset is held, releases reset, and compares done latency and the
// box against a reference computed directly from the image contents.

module tb_bounding_box_top;

  localparam int W    = 100;
  localparam int H    = 100;
  localparam int NPIX = W * H;

  logic       CLOCK_50;
  logic [3:0] KEY;

  int vectors;
  int miscompares;

  logic [7:0] img [0:NPIX-1];

  bounding_box_top dut (
    .CLOCK_50 (CLOCK_50),
    .KEY      (KEY)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit is_fg(input logic [7:0] v);
`ifdef BBOX_THRESHOLD_EN
    return (v >= 8'd128);
`else
    return (v != 8'd0);
`endif
  endfunction

  // Bounding box over the first npix pixels in raster order
  task automatic model(input int npix, output int xmn, output int ymn,
                       output int xmx, output int ymx);
    xmn = 127; ymn = 127; xmx = 0; ymx = 0;
    for (int i = 0; i < npix; i++) begin
      if (is_fg(img[i])) begin
        if (i % W < xmn) xmn = i % W;
        if (i % W > xmx) xmx = i % W;
        if (i / W < ymn) ymn = i / W;
        if (i / W > ymx) ymx = i / W;
      end
    end
  endtask

  task automatic clear_img();
    for (int i = 0; i < NPIX; i++) img[i] = 8'd0;
  endtask

  task automatic put(input int x, input int y, input logic [7:0] v);
    img[y * W + x] = v;
  endtask

  task automatic hold_and_load();
    @(negedge CLOCK_50);
    KEY = 4'b0111;
    for (int i = 0; i < NPIX; i++) dut.ram[i] = img[i];
    @(negedge CLOCK_50);
  endtask

  task automatic run_scan(input string name);
    int xmn, ymn, xmx, ymx, rise;
    logic [6:0] hold_x;
    hold_and_load();
    model(NPIX, xmn, ymn, xmx, ymx);
    KEY = 4'b1111;
    rise = 0;
    for (int c = 1; c <= NPIX + 10; c++) begin
      @(posedge CLOCK_50);
      #1;
      if (dut.done === 1'b1) begin
        rise = c;
        break;
      end
    end
    chk({name, "_latency"}, rise, NPIX + 2);
    chk({name, "_xMin"}, 32'(dut.xMin), xmn);
    chk({name, "_yMin"}, 32'(dut.yMin), ymn);
    chk({name, "_xMax"}, 32'(dut.xMax), xmx);
    chk({name, "_yMax"}, 32'(dut.yMax), ymx);
    hold_x = dut.xMin;
    repeat (5) @(posedge CLOCK_50);
    #1;
    chk({name, "_done_hold"}, 32'(dut.done), 1);
    chk({name, "_xMin_hold"}, 32'(dut.xMin), 32'(hold_x));
  endtask

  initial begin
    int xmn, ymn, xmx, ymx, n;
    vectors = 0;
    miscompares = 0;
    KEY = 4'b1111;
    #1;
    KEY = 4'b0111;
    #2;
    chk("rst_done", 32'(dut.done), 0);
    chk("rst_xMin", 32'(dut.xMin), 127);
    chk("rst_yMin", 32'(dut.yMin), 127);
    chk("rst_xMax", 32'(dut.xMax), 0);
    chk("rst_yMax", 32'(dut.yMax), 0);

    // Rectangle x 28..79, y 29..65
    clear_img();
    for (int y = 29; y <= 65; y++)
      for (int x = 28; x <= 79; x++) put(x, y, 8'($urandom_range(128, 255)));
    run_scan("rect");

    // Single pixel at the far corner
    clear_img();
    put(99, 99, 8'hFF);
    run_scan("px99");

    // Single pixel at the origin
    clear_img();
    put(0, 0, 8'hC8);
    run_scan("px00");

    // Empty image
    clear_img();
    run_scan("empty");

    // Reset in the middle of a rectangle scan
    clear_img();
    for (int y = 29; y <= 65; y++)
      for (int x = 28; x <= 79; x++) put(x, y, 8'hFF);
    hold_and_load();
    KEY = 4'b1111;
    repeat (3000) @(posedge CLOCK_50);
    #1;
    model(2999, xmn, ymn, xmx, ymx);
    chk("mid_done", 32'(dut.done), 0);
    chk("mid_xMin", 32'(dut.xMin), xmn);
    chk("mid_yMax", 32'(dut.yMax), ymx);
    KEY = 4'b0111;
    #1;
    chk("mid_rst_xMin", 32'(dut.xMin), 127);
    chk("mid_rst_xMax", 32'(dut.xMax), 0);
    chk("mid_rst_yMax", 32'(dut.yMax), 0);
    clear_img();
    put(50, 40, 8'hFF);
    run_scan("after_mid");

    // Sub/over-threshold pair plus random extra pixels in the lower rows
    clear_img();
    put(10, 10, 8'd127);
    put(20, 30, 8'd200);
    n = $urandom_range(1, 4);
    for (int k = 0; k < n; k++)
      put($urandom_range(0, 99), $urandom_range(40, 99), 8'($urandom_range(0, 255)));
    run_scan("thresh_rand");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
